// File: rtl/tpmem_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tpmem_seq_ctrl
//
// Sequencer wrapped around a 16x16 transpose memory. It sits between the
// row-transform stage and the column-transform stage.
//
// Write side:
//   - Accepts 16 rows per block over a valid/ready handshake.
//   - Replays them to the memory as one unbroken 16-cycle write-enable burst.
//   - Drops ready for the 16-cycle column drain, so the memory is never
//     written while columns are still unread.
//
// Read side:
//   - Registers the drained columns.
//   - Tags each column with its index, a last flag and a completed-block count.
//
// Error pulse (o_err), one cycle wide, for either of:
//   - an upstream stall mid-block (abort), or
//   - a column train that stops early (broken drain).
//
// Ports:
//   i_clk        clock, rising edge
//   i_Reset      synchronous active-low reset
//   i_valid      upstream row valid
//   i_data       upstream row, element 0 in the MSBs
//   o_ready      row accepted when i_valid && o_ready
//   o_tp_enable  transpose memory write enable
//   o_tp_data    transpose memory write data
//   i_tp_en      transpose memory column valid
//   i_tp_data    transpose memory column data
//   o_valid      column valid downstream
//   o_data       column data (zero when o_valid is low)
//   o_col_idx    column index 0..15
//   o_last       high with column 15
//   o_blk_cnt    blocks fully drained, wraps
//   o_err        one-cycle error pulse
//   o_busy       FSM not idle
// -----------------------------------------------------------------------------
module tpmem_seq_ctrl #(
   parameter int unsigned BW    = 11,
   parameter int unsigned CNT_W = 8
) (
   input  logic               i_clk,
   input  logic               i_Reset,
   input  logic               i_valid,
   input  logic [16*BW-1:0]   i_data,
   output logic               o_ready,
   output logic               o_tp_enable,
   output logic [16*BW-1:0]   o_tp_data,
   input  logic               i_tp_en,
   input  logic [16*BW-1:0]   i_tp_data,
   output logic               o_valid,
   output logic [16*BW-1:0]   o_data,
   output logic [3:0]         o_col_idx,
   output logic               o_last,
   output logic [CNT_W-1:0]   o_blk_cnt,
   output logic               o_err,
   output logic               o_busy
);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StDrain
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] rcnt_q, rcnt_d;
   logic [3:0] dcnt_q, dcnt_d;
   logic [3:0] ccnt_q, ccnt_d;
   logic       accept;
   logic       abort;
   logic       broken;

   // Ready depends on the state register only, never on i_valid.
   assign o_ready = (state_q != StDrain);
   assign o_busy  = (state_q != StIdle);
   assign accept  = i_valid && o_ready;

   // ---------------------------------------------------------------------------
   // Row sequencing FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      dcnt_d  = dcnt_q;
      abort   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               rcnt_d  = 4'd1;
               state_d = StLoad;
            end
         end
         StLoad: begin
            if (!i_valid) begin
               // The memory discards a partial block once its enable drops,
               // so the block cannot be resumed.
               abort   = 1'b1;
               rcnt_d  = 4'd0;
               state_d = StIdle;
            end else if (rcnt_q == 4'd15) begin
               rcnt_d  = 4'd0;
               dcnt_d  = 4'd0;
               state_d = StDrain;
            end else begin
               rcnt_d = rcnt_q + 4'd1;
            end
         end
         StDrain: begin
            if (dcnt_q == 4'd15) begin
               dcnt_d  = 4'd0;
               state_d = StIdle;
            end else begin
               dcnt_d = dcnt_q + 4'd1;
            end
         end
         default: begin
            state_d = StIdle;
            rcnt_d  = 4'd0;
            dcnt_d  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_Reset) begin
         state_q <= StIdle;
         rcnt_q  <= 4'd0;
         dcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         dcnt_q  <= dcnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Write path: the accepted row goes out on the next cycle; data holds between
   // bursts.
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (!i_Reset) begin
         o_tp_enable <= 1'b0;
         o_tp_data   <= '0;
      end else begin
         o_tp_enable <= accept;
         if (accept) begin
            o_tp_data <= i_data;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Column path: independent of the FSM, driven purely by the memory's i_tp_en.
   // ---------------------------------------------------------------------------
   // A column train that stops before 16 columns leaves ccnt non-zero.
   assign broken = !i_tp_en && (ccnt_q != 4'd0);

   always_comb begin
      ccnt_d = ccnt_q;
      if (i_tp_en) begin
         ccnt_d = ccnt_q + 4'd1;   // wraps 15 -> 0 at the end of a full block
      end else if (broken) begin
         ccnt_d = 4'd0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_Reset) begin
         ccnt_q    <= 4'd0;
         o_valid   <= 1'b0;
         o_data    <= '0;
         o_col_idx <= 4'd0;
         o_last    <= 1'b0;
         o_blk_cnt <= '0;
         o_err     <= 1'b0;
      end else begin
         ccnt_q    <= ccnt_d;
         o_valid   <= i_tp_en;
         o_data    <= i_tp_en ? i_tp_data : '0;
         o_col_idx <= ccnt_q;
         o_last    <= i_tp_en && (ccnt_q == 4'd15);
         // Count the block once its last column has been presented.
         if (o_last) begin
            o_blk_cnt <= o_blk_cnt + 1'b1;
         end
         // Abort and broken drain may coincide; either way, one pulse.
         o_err <= abort || broken;
      end
   end

endmodule

// File: tb/tb_tpmem_seq_ctrl.sv
module tb_tpmem_seq_ctrl;

   localparam int unsigned BW = 11;
   localparam int unsigned RW = 16 * BW;

   typedef logic [RW-1:0] blk_t [16];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b1;
   logic          valid = 1'b0;
   logic [RW-1:0] din   = '0;

   // Primary DUT (CNT_W=8) outputs
   logic          ready, tp_en, vld, last, err, busy;
   logic [RW-1:0] tp_data, dout;
   logic [3:0]    col_idx;
   logic [7:0]    blk;

   // Second DUT (CNT_W=2) outputs, used for the counter-wrap checks
   logic          ready_w, tp_en_w, vld_w, last_w, err_w, busy_w;
   logic [RW-1:0] tp_data_w, dout_w;
   logic [3:0]    col_idx_w;
   logic [1:0]    blk_w;

   // Memory feedback, optionally overridden by the bench
   logic          m_en;
   logic [RW-1:0] m_data;
   logic          ovr     = 1'b0;
   logic          ovr_en  = 1'b0;
   logic [RW-1:0] ovr_data = '0;
   logic          tp_en_in;
   logic [RW-1:0] tp_data_in;

   assign tp_en_in   = ovr ? ovr_en : m_en;
   assign tp_data_in = ovr ? ovr_data : m_data;

   tpmem_seq_ctrl #(.BW(BW), .CNT_W(8)) u_dut (
      .i_clk(clk), .i_Reset(rst_n), .i_valid(valid), .i_data(din),
      .o_ready(ready), .o_tp_enable(tp_en), .o_tp_data(tp_data),
      .i_tp_en(tp_en_in), .i_tp_data(tp_data_in),
      .o_valid(vld), .o_data(dout), .o_col_idx(col_idx), .o_last(last),
      .o_blk_cnt(blk), .o_err(err), .o_busy(busy)
   );

   tpmem_seq_ctrl #(.BW(BW), .CNT_W(2)) u_dut_w (
      .i_clk(clk), .i_Reset(rst_n), .i_valid(valid), .i_data(din),
      .o_ready(ready_w), .o_tp_enable(tp_en_w), .o_tp_data(tp_data_w),
      .i_tp_en(tp_en_in), .i_tp_data(tp_data_in),
      .o_valid(vld_w), .o_data(dout_w), .o_col_idx(col_idx_w), .o_last(last_w),
      .o_blk_cnt(blk_w), .o_err(err_w), .o_busy(busy_w)
   );

   // Column k of a block: element r is element k of row r (element 0 in MSBs).
   function automatic logic [RW-1:0] col_of(input blk_t rows, input int k);
      logic [RW-1:0] c;
      c = '0;
      for (int r = 0; r < 16; r++) c[(15-r)*BW +: BW] = rows[r][(15-k)*BW +: BW];
      return c;
   endfunction

   // Transpose memory: 16 enabled writes, then 16 column reads; a gap in the
   // enable mid-write discards the partial block.
   blk_t       mem;
   logic [4:0] mcnt;
   always @(posedge clk) begin
      if (!rst_n) begin
         mcnt   <= 5'd0;
         m_en   <= 1'b0;
         m_data <= '0;
      end else begin
         if (mcnt < 5'd16) begin
            if (tp_en) begin
               mem[mcnt[3:0]] <= tp_data;
               mcnt <= mcnt + 5'd1;
            end else begin
               mcnt <= 5'd0;
            end
         end else begin
            mcnt <= mcnt + 5'd1;
         end
         m_en   <= (mcnt >= 5'd16);
         m_data <= (mcnt >= 5'd16) ? col_of(mem, int'(mcnt) - 16) : '0;
      end
   end

   // Reference model state: what the bench expects, cycle by cycle.
   int            cyc = 0;
   int            nchk = 0;
   int            nfail = 0;
   int            rows_got = 0;
   int            drain_left = 0;
   int            exp_blk = 0;
   blk_t          cur;
   logic          exp_tpen = 1'b0;
   logic [RW-1:0] exp_tpdata = '0;
   logic [RW-1:0] s_data [int];
   int            s_idx  [int];
   bit            s_last [int];
   bit            s_err  [int];
   bit            s_inc  [int];

   task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      rows_got   = 0;
      drain_left = 0;
      exp_blk    = 0;
      exp_tpen   = 1'b0;
      exp_tpdata = '0;
      s_data.delete();
      s_idx.delete();
      s_last.delete();
      s_err.delete();
      s_inc.delete();
   endtask

   task automatic check_outputs();
      chk("ready", RW'(ready), RW'(drain_left == 0));
      chk("busy", RW'(busy), RW'(rows_got > 0 || drain_left > 0));
      chk("tp_enable", RW'(tp_en), RW'(exp_tpen));
      chk("tp_data", tp_data, exp_tpdata);
      chk("valid", RW'(vld), RW'(s_data.exists(cyc)));
      chk("data", dout, s_data.exists(cyc) ? s_data[cyc] : '0);
      if (s_data.exists(cyc)) chk("col_idx", RW'(col_idx), RW'(s_idx[cyc]));
      chk("last", RW'(last), RW'(s_last.exists(cyc)));
      chk("err", RW'(err), RW'(s_err.exists(cyc)));
      chk("blk_cnt", RW'(blk), RW'(exp_blk % 256));
      chk("blk_cnt_w2", RW'(blk_w), RW'(exp_blk % 4));
   endtask

   // Advance one cycle: update the model from the inputs of the current cycle,
   // then compare everything in the next cycle.
   task automatic tick();
      bit acc;
      acc = valid && (drain_left == 0);
      if (drain_left > 0) drain_left--;
      if (!rst_n) begin
         model_reset();
      end else begin
         exp_tpen = acc;
         if (acc) begin
            exp_tpdata    = din;
            cur[rows_got] = din;
            rows_got++;
            if (rows_got == 16) begin
               for (int k = 0; k < 16; k++) begin
                  s_data[cyc+4+k] = col_of(cur, k);
                  s_idx[cyc+4+k]  = k;
               end
               s_last[cyc+19] = 1'b1;
               s_inc[cyc+20]  = 1'b1;
               rows_got   = 0;
               drain_left = 16;
            end
         end else if (rows_got > 0) begin
            s_err[cyc+1] = 1'b1;
            rows_got     = 0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (s_inc.exists(cyc)) exp_blk++;
      check_outputs();
   endtask

   function automatic logic [RW-1:0] rand_row();
      logic [RW-1:0] r;
      for (int e = 0; e < 16; e++) r[e*BW +: BW] = BW'($urandom_range(0, (1 << BW) - 1));
      return r;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rand_block();
      for (int r = 0; r < 16; r++) begin
         valid = 1'b1;
         din   = rand_row();
         tick();
      end
      valid = 1'b0;
   endtask

   int wrap_exp [5] = '{1, 2, 3, 0, 1};

   initial begin
      do_reset();

      // Single block with element c of row r = 16*r + c
      for (int r = 0; r < 16; r++) begin
         valid = 1'b1;
         for (int c = 0; c < 16; c++) din[(15-c)*BW +: BW] = BW'(16 * r + c);
         tick();
      end
      idle(25);
      chk("single_blk_cnt", RW'(blk), RW'(1));

      // Continuous valid for 64 cycles: two blocks, back to back
      do_reset();
      for (int i = 0; i < 64; i++) begin
         valid = 1'b1;
         din   = rand_row();
         tick();
      end
      idle(40);
      chk("cont_blk_cnt", RW'(blk), RW'(2));

      // Abort after 7 rows, then a full block
      do_reset();
      for (int r = 0; r < 7; r++) begin
         valid = 1'b1;
         din   = rand_row();
         tick();
      end
      idle(10);
      rand_block();
      idle(25);
      chk("abort_blk_cnt", RW'(blk), RW'(1));

      // Reset in the 9th drain cycle (cycle 24 of the block)
      do_reset();
      rand_block();
      idle(8);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst_ready", RW'(ready), RW'(1));
      idle(30);
      chk("rst_blk_cnt", RW'(blk), RW'(0));

      // Counter wrap on the CNT_W=2 instance
      for (int b = 0; b < 5; b++) begin
         rand_block();
         idle(24);
         chk("wrap_blk_cnt_w2", RW'(blk_w), RW'(wrap_exp[b]));
      end

      // Broken drain: the bench drives the column side directly
      ovr = 1'b1;
      for (int t = 0; t < 2; t++) begin
         for (int j = 0; j < (t == 0 ? 5 : 3); j++) begin
            ovr_en   = 1'b1;
            ovr_data = rand_row();
            s_data[cyc+1] = ovr_data;
            s_idx[cyc+1]  = j;
            tick();
         end
         ovr_en   = 1'b0;
         ovr_data = rand_row();
         s_err[cyc+1] = 1'b1;
         tick();
         idle(3);
      end
      ovr = 1'b0;
      idle(5);
      chk("broken_blk_cnt", RW'(blk), RW'(exp_blk % 256));
      chk("broken_blk_cnt_fixed", RW'(blk), RW'(5));

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
      $finish;
   end

endmodule
